change_dispense_ctrl: RTL
=========================

Name: change_dispense_ctrl

Overview:
Sequences physical change return for the vending machine once a purchase or cancel has computed the change owed in cents. Uses greedy largest-coin-first selection and skips denominations whose hopper reports empty. Issues one eject pulse per coin to the dispenser mechanics and waits for each coin's drop confirmation. Sits between the purchase/credit logic, which supplies start and amount, and the coin/bill dispenser drivers.

Parameters:
CENTS_W, 10, width of amount and remaining in cents; must hold at least 500.
PULSE_CYCLES, 4, clock cycles each eject line is held high; must be at least 1.
TIMEOUT_CYCLES, 1000, maximum cycles spent in WAIT_ACK before a jam error.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin dispensing; sampled only in IDLE
amount  in  CENTS_W  change owed in cents; latched when start is accepted
empty  in  6  hopper empty flags {five,dollar,fifty,quarter,dime,nickel}
coin_ack  in  1  dispenser pulse confirming one item dropped
clear  in  1  leaves ERROR and returns to IDLE
eject  out  6  one-hot eject strobe, same bit order as empty
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on successful completion
err  out  1  high while in ERROR
err_jam  out  1  high in ERROR when the cause was a timeout
remaining  out  CENTS_W  cents still owed

Behaviour:
- Reset (async, rst_n=0): state IDLE, remaining=0, eject=0, busy=0, done=0, err=0, err_jam=0, all counters 0.
- Denomination values: five=500, dollar=100, fifty=50, quarter=25, dime=10, nickel=5 cents.
- IDLE:
  - start=1 latches amount into remaining, then goes to SELECT.
  - Eject, done and err are all low.
- SELECT (one cycle):
  - remaining==0 goes to DONE.
  - Otherwise picks the largest denomination d with d<=remaining and empty[d]==0, then goes to EJECT.
  - If no denomination qualifies, goes to ERROR with err_jam=0. This covers remaining<5 and exhausted stock.
- EJECT: drives eject one-hot for exactly PULSE_CYCLES cycles, then goes to WAIT_ACK with eject=0.
- WAIT_ACK:
  - coin_ack=1 subtracts the selected denomination from remaining (never underflows, since d<=remaining) and goes to SELECT.
  - Otherwise increments the timeout counter. Reaching TIMEOUT_CYCLES goes to ERROR with err_jam=1.
- coin_ack outside WAIT_ACK is ignored; an early ack during EJECT is not counted.
- DONE: done=1 for one cycle, then goes to IDLE.
- ERROR:
  - err=1, busy=1, remaining holds the amount still owed.
  - clear=1 goes to IDLE, with remaining retained for display until the next start.
- start while busy is ignored, with no queuing.
- start and clear in the same cycle in ERROR: clear wins. Start is not sampled in that cycle.
- empty may change at any time. It is sampled only in SELECT; a hopper emptying during EJECT/WAIT_ACK does not abort the current coin.
- Reset mid-operation immediately drops eject and discards remaining.
- Latency, all stock present:
  - Per coin: 1 (SELECT) + PULSE_CYCLES + ack wait.
  - amount=0: done pulses 2 cycles after start (SELECT, then DONE).

Optional Feature:
COIN_COUNT_EN
- Defined: adds output coin_count[7:0], the number of items dispensed in the current transaction.
  - Cleared when start is accepted.
  - Incremented on each accepted coin_ack.
  - Saturates at 255.
  - Held through DONE, IDLE and ERROR until the next start.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- No empties, start with amount=65 -> eject sequence fifty, dime, nickel. Each eject is high 4 cycles, remaining 65->15->5->0, then one done pulse, busy low.
- empty quarter=1, amount=40 -> four dime ejects, never fifty or quarter, then done; with COIN_COUNT_EN, coin_count=4.
- amount=7 -> one nickel, remaining=2, then ERROR with err=1, err_jam=0. clear -> IDLE, remaining stays 2.
- amount=100 with no coin_ack ever -> dollar eject, then ERROR after exactly TIMEOUT_CYCLES WAIT_ACK cycles with err_jam=1, remaining=100.
- rst_n low on the 2nd cycle of a dollar eject -> eject=0 and all outputs at reset values immediately (async); the next start for amount=5 completes normally.
- Second start and an early coin_ack during EJECT of an amount=10 run -> both ignored; exactly one dime is dispensed and one done pulse occurs.

Source files
------------

// File: rtl/change_dispense_if.sv
// Change dispenser handshake bundle between the purchase/credit logic
// (master) and the change dispense controller (slave).
// Optional macro: COIN_COUNT_EN adds the coin_count status signal.
interface change_dispense_if #(
  parameter int CENTS_W = 10
);
  logic               start;
  logic [CENTS_W-1:0] amount;
  logic [5:0]         empty;
  logic               coin_ack;
  logic               clear;
  logic [5:0]         eject;
  logic               busy;
  logic               done;
  logic               err;
  logic               err_jam;
  logic [CENTS_W-1:0] remaining;
`ifdef COIN_COUNT_EN
  logic [7:0]         coin_count;

  modport master (
    output start, amount, empty, coin_ack, clear,
    input  eject, busy, done, err, err_jam, remaining, coin_count
  );

  modport slave (
    input  start, amount, empty, coin_ack, clear,
    output eject, busy, done, err, err_jam, remaining, coin_count
  );
`else
  modport master (
    output start, amount, empty, coin_ack, clear,
    input  eject, busy, done, err, err_jam, remaining
  );

  modport slave (
    input  start, amount, empty, coin_ack, clear,
    output eject, busy, done, err, err_jam, remaining
  );
`endif
endinterface

// File: rtl/change_dispense_ctrl.sv
// Change dispense controller: greedy largest-coin-first selection that skips
// empty hoppers, one eject strobe per coin, waits for the drop confirmation
// and flags a jam when that confirmation never arrives.
// Optional macro: COIN_COUNT_EN adds a saturating per-transaction coin count.
// Denomination bit order for empty/eject: {five,dollar,fifty,quarter,dime,nickel}.
module change_dispense_ctrl #(
  parameter int CENTS_W        = 10,
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  change_dispense_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_EJECT  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam int PULSE_W = $clog2(PULSE_CYCLES + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

  // Coin value in cents for a denomination index (0 = nickel ... 5 = five).
  function automatic logic [CENTS_W-1:0] denom(input logic [2:0] idx);
    case (idx)
      3'd0:    denom = CENTS_W'(5);
      3'd1:    denom = CENTS_W'(10);
      3'd2:    denom = CENTS_W'(25);
      3'd3:    denom = CENTS_W'(50);
      3'd4:    denom = CENTS_W'(100);
      default: denom = CENTS_W'(500);
    endcase
  endfunction

  logic [2:0]         state_q, state_d;
  logic [CENTS_W-1:0] remaining_q, remaining_d;
  logic [2:0]         sel_q, sel_d;
  logic [PULSE_W-1:0] pulse_q, pulse_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               jam_q, jam_d;
  logic               found;
  logic [2:0]         pick;
`ifdef COIN_COUNT_EN
  logic [7:0]         cnt_q, cnt_d;
`endif

  // Greedy pick: ascending scan, so the last qualifying index is the largest coin.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    pick  = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (!bus.empty[i] && (denom(3'(i)) <= remaining_q)) begin
        found = 1'b1;
        pick  = 3'(i);
      end
    end
  end

  // Next-state and datapath update for the dispense sequence.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    sel_d       = sel_q;
    pulse_d     = pulse_q;
    tmo_d       = tmo_q;
    jam_d       = jam_q;
`ifdef COIN_COUNT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          remaining_d = bus.amount;
          jam_d       = 1'b0;
`ifdef COIN_COUNT_EN
          cnt_d       = 8'd0;
`endif
          state_d     = S_SELECT;
        end
      end
      S_SELECT: begin
        if (remaining_q == '0) begin
          state_d = S_DONE;
        end else if (found) begin
          sel_d   = pick;
          pulse_d = '0;
          state_d = S_EJECT;
        end else begin
          jam_d   = 1'b0;
          state_d = S_ERROR;
        end
      end
      S_EJECT: begin
        if (pulse_q == PULSE_W'(PULSE_CYCLES - 1)) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end else begin
          pulse_d = pulse_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.coin_ack) begin
          // The pick guaranteed denom <= remaining, so this cannot underflow.
          remaining_d = remaining_q - denom(sel_q);
`ifdef COIN_COUNT_EN
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
`endif
          state_d     = S_SELECT;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          jam_d   = 1'b1;
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: if (bus.clear) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is small control state, so all of it is reset; no storage array is left unreset.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      sel_q       <= 3'd0;
      pulse_q     <= '0;
      tmo_q       <= '0;
      jam_q       <= 1'b0;
`ifdef COIN_COUNT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      remaining_q <= remaining_d;
      sel_q       <= sel_d;
      pulse_q     <= pulse_d;
      tmo_q       <= tmo_d;
      jam_q       <= jam_d;
`ifdef COIN_COUNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Outputs decode directly from state, so reset drops eject immediately.
  assign bus.eject     = (state_q == S_EJECT) ? (6'b000001 << sel_q) : 6'b000000;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = (state_q == S_ERROR);
  assign bus.err_jam   = (state_q == S_ERROR) && jam_q;
  assign bus.remaining = remaining_q;
`ifdef COIN_COUNT_EN
  assign bus.coin_count = cnt_q;
`endif

endmodule
